// File: rtl/mult_job_sequencer_if.sv
// Handshake bundle between the job sequencer, its operand producer, the
// external multiplier and the result consumer.
interface mult_job_sequencer_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_multiplicand;
    logic [N-1:0]     in_multiplier;

    logic             mul_start;
    logic [N-1:0]     mul_multiplicand;
    logic [N-1:0]     mul_multiplier;
    logic [2*N-1:0]   mul_product;
    logic             mul_done;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_multiplicand;
    logic [N-1:0]     out_multiplier;
    logic [2*N-1:0]   out_product;

    logic [CW-1:0]    count;
    logic             busy;

    // Sequencer side.
    modport slave (
        input  in_valid, in_multiplicand, in_multiplier,
        input  mul_product, mul_done, out_ready,
        output in_ready, mul_start, mul_multiplicand, mul_multiplier,
        output out_valid, out_multiplicand, out_multiplier, out_product,
        output count, busy
    );

    // Environment side: producer, multiplier and consumer.
    modport master (
        output in_valid, in_multiplicand, in_multiplier,
        output mul_product, mul_done, out_ready,
        input  in_ready, mul_start, mul_multiplicand, mul_multiplier,
        input  out_valid, out_multiplicand, out_multiplier, out_product,
        input  count, busy
    );
endinterface

// File: rtl/mult_job_sequencer.sv
// Buffers operand pairs in a FIFO, issues them one at a time to an external
// multiplier via start/done, and returns each product with its operands.
module mult_job_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_job_sequencer_if.slave   job
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_CLEAR} state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N-1:0]     iss_a_q, iss_a_d;
    logic [N-1:0]     iss_b_q, iss_b_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_a_q, out_a_d;
    logic [N-1:0]     out_b_q, out_b_d;
    logic [2*N-1:0]   out_p_q, out_p_d;

    logic push;
    logic issue_go;
    logic out_pop;

    // in_ready comes from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign job.in_ready = (count_q < CW'(DEPTH));
    assign push         = job.in_valid && job.in_ready;
    assign out_pop      = out_valid_q && job.out_ready;
    assign issue_go     = (state_q == IDLE) && (count_q != '0) && !job.mul_done
                          && (!out_valid_q || job.out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {job.in_multiplicand, job.in_multiplier};
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_p_d     = out_p_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (out_pop) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // Head is popped on the way into ISSUE so operands are
                // already stable while mul_start is high.
                if (issue_go) begin
                    state_d            = ISSUE;
                    {iss_a_d, iss_b_d} = fifo_mem_q[rd_ptr_q];
                    rd_ptr_d           = rd_ptr_q + 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (job.mul_done) begin
                    out_valid_d = 1'b1;
                    out_a_d     = iss_a_q;
                    out_b_d     = iss_b_q;
                    out_p_d     = job.mul_product;
                    state_d     = WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                if (!job.mul_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case ({push, issue_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_p_q     <= out_p_d;
        end
    end

    assign job.mul_start        = (state_q == ISSUE);
    assign job.mul_multiplicand = iss_a_q;
    assign job.mul_multiplier   = iss_b_q;
    assign job.out_valid        = out_valid_q;
    assign job.out_multiplicand = out_a_q;
    assign job.out_multiplier   = out_b_q;
    assign job.out_product      = out_p_q;
    assign job.count            = count_q;
    assign job.busy             = (state_q != IDLE) || (count_q != '0) || out_valid_q;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: behavioural multiplier, result scoreboard,
// a job table and hand-written corner-case sequences.
module tb_mult_job_sequencer;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_job_sequencer_if #(.N(N), .DEPTH(DEPTH)) bus ();
    mult_job_sequencer #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .job(bus));

    int   checks   = 0;
    int   failures = 0;
    int   starts   = 0;
    int   lat      = 2;
    int   hold     = 2;
    logic stale    = 1'b0;
    job_t sb[$];

    // Behavioural multiplier: fixed latency, done held for a few cycles.
    logic           model_done;
    logic [2*N-1:0] model_prod;
    int             mph;
    int             mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mph <= 0; mcnt <= 0; model_done <= 1'b0; model_prod <= '0;
        end else begin
            case (mph)
                0: if (bus.mul_start) begin
                    mph        <= 1;
                    mcnt       <= lat;
                    model_prod <= {4'b0, bus.mul_multiplicand} * {4'b0, bus.mul_multiplier};
                end
                1: if (mcnt <= 1) begin
                    mph <= 2; mcnt <= hold; model_done <= 1'b1;
                end else mcnt <= mcnt - 1;
                default: if (mcnt <= 1) begin
                    mph <= 0; model_done <= 1'b0;
                end else mcnt <= mcnt - 1;
            endcase
        end
    end
    assign bus.mul_done    = model_done | stale;
    assign bus.mul_product = model_prod;

    // Inputs change 1 time unit after posedge; negedge sees what the next posedge samples.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mul_start) begin
                starts++;
                checks++;
                if (bus.mul_done) begin
                    failures++;
                    $display("FAIL start_vs_done got mul_done=1 during mul_start, required 0");
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got a=%0d b=%0d p=%0d, required no result",
                             bus.out_multiplicand, bus.out_multiplier, bus.out_product);
                end else begin
                    job_t e;
                    e = sb.pop_front();
                    if (bus.out_multiplicand !== e.a || bus.out_multiplier !== e.b ||
                        bus.out_product !== e.p) begin
                        failures++;
                        $display("FAIL result got %0d*%0d=%0d, required %0d*%0d=%0d",
                                 bus.out_multiplicand, bus.out_multiplier, bus.out_product,
                                 e.a, e.b, e.p);
                    end else begin
                        $display("result %0d*%0d=%0d ok", e.a, e.b, e.p);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_job(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [2*N-1:0] p);
        int t;
        job_t e;
        t = 0;
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = a;
        bus.in_multiplier   = b;
        while (!bus.in_ready && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (bus.in_ready) begin
            e.a = a; e.b = b; e.p = p;
            sb.push_back(e);
            step();
        end else begin
            failures++;
            $display("FAIL push_timeout got in_ready=0 for %0d*%0d, required 1", a, b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((bus.busy || sb.size() != 0) && t < budget) begin
            step();
            t++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("drain_busy", {31'b0, bus.busy}, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'b0, bus.in_ready}, 1);
        chk({tag, "_mul_start"}, {31'b0, bus.mul_start}, 0);
        chk({tag, "_mul_a"},     bus.mul_multiplicand, 0);
        chk({tag, "_mul_b"},     bus.mul_multiplier, 0);
        chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 0);
        chk({tag, "_out_a"},     bus.out_multiplicand, 0);
        chk({tag, "_out_b"},     bus.out_multiplier, 0);
        chk({tag, "_out_p"},     bus.out_product, 0);
        chk({tag, "_count"},     bus.count, 0);
        chk({tag, "_busy"},      {31'b0, bus.busy}, 0);
    endtask

    job_t vecs [8];

    initial begin
        int s0;
        int t;
        logic [2*N-1:0] held_p;

        vecs[0] = '{a: 4'd8,  b: 4'd4,  p: 8'd32};
        vecs[1] = '{a: 4'd7,  b: 4'd9,  p: 8'd63};
        vecs[2] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        vecs[4] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
        vecs[5] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        vecs[6] = '{a: 4'd12, b: 4'd10, p: 8'd120};
        vecs[7] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};

        bus.in_valid        = 1'b0;
        bus.in_multiplicand = '0;
        bus.in_multiplier   = '0;
        bus.out_ready       = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Single job 11x13 with exact start timing.
        bus.in_valid = 1'b1; bus.in_multiplicand = 4'd11; bus.in_multiplier = 4'd13;
        sb.push_back('{a: 4'd11, b: 4'd13, p: 8'd143});
        step();
        bus.in_valid = 1'b0;
        chk("single_count_after_push", bus.count, 1);
        chk("single_no_early_start", {31'b0, bus.mul_start}, 0);
        step();
        chk("single_start", {31'b0, bus.mul_start}, 1);
        chk("single_mul_a", bus.mul_multiplicand, 11);
        chk("single_mul_b", bus.mul_multiplier, 13);
        step();
        chk("single_start_one_cycle", {31'b0, bus.mul_start}, 0);
        wait_idle(100);

        // Table jobs pushed back to back.
        for (int i = 0; i < 8; i++) push_job(vecs[i].a, vecs[i].b, vecs[i].p);
        wait_idle(300);

        // Output back-pressure: one held result, FIFO fills, extra push refused.
        bus.out_ready = 1'b0;
        push_job(4'd2, 4'd3, 8'd6);
        t = 0;
        while (!bus.out_valid && t < 50) begin step(); t++; end
        chk("bp_held_valid", {31'b0, bus.out_valid}, 1);
        held_p = bus.out_product;
        chk("bp_held_product", held_p, 6);
        s0 = starts;
        push_job(4'd5, 4'd5, 8'd25);
        push_job(4'd6, 4'd6, 8'd36);
        push_job(4'd7, 4'd7, 8'd49);
        push_job(4'd9, 4'd9, 8'd81);
        chk("bp_count_full", bus.count, DEPTH);
        bus.in_valid = 1'b1; bus.in_multiplicand = 4'd1; bus.in_multiplier = 4'd2;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready_low", {31'b0, bus.in_ready}, 0);
            step();
            chk("bp_count_stays", bus.count, DEPTH);
            chk("bp_product_stable", bus.out_product, 6);
            chk("bp_valid_stable", {31'b0, bus.out_valid}, 1);
        end
        bus.in_valid = 1'b0;
        chk("bp_no_issue", starts, s0);
        bus.out_ready = 1'b1;
        wait_idle(300);

        // All 256 operand pairs.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                push_job(4'(a), 4'(b), 8'(a * b));
        wait_idle(5000);

        // Reset while waiting on the multiplier with two jobs queued.
        lat = 10;
        push_job(4'd4, 4'd4, 8'd16);
        push_job(4'd5, 4'd5, 8'd25);
        push_job(4'd6, 4'd6, 8'd36);
        step();
        step();
        chk("rst_queued", bus.count, 2);
        chk("rst_in_flight", {31'b0, bus.busy}, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        s0 = starts;
        step();
        step();
        rst = 1'b0;
        lat = 2;
        repeat (20) step();
        chk("postrst_no_start", starts, s0);
        chk("postrst_no_valid", {31'b0, bus.out_valid}, 0);
        push_job(4'd3, 4'd5, 8'd15);
        wait_idle(100);

        // Stale mul_done while idle blocks issue until it drops.
        stale = 1'b1;
        step();
        s0 = starts;
        push_job(4'd9, 4'd7, 8'd63);
        repeat (6) step();
        chk("stale_no_start", starts, s0);
        chk("stale_count", bus.count, 1);
        stale = 1'b0;
        wait_idle(100);
        chk("stale_one_start", starts, s0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
